serv_wake_ctrl: RTL and testbench

SERV_WAKE_CTRL -- requirements
Module: serv_wake_ctrl

---
 rtl/serv_wake_pkg.sv | 16 +
 rtl/serv_wake_ctrl.sv | 131 +++++++++++++
 tb/tb_serv_wake_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serv_wake_pkg.sv
// Shared types and constants for the SERV sleep/wake controller.
// The wake-cause bit positions are only consumed when SERV_WAKE_CAUSE_EN is defined.
package serv_wake_pkg;

    localparam int CNT_W           = 4;
    localparam int CAUSE_TIMER_BIT = 0;
    localparam int CAUSE_EXT_BIT   = 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_WAKE  = 2'd3
    } wake_state_e;

endpackage

// File: rtl/serv_wake_ctrl.sv
// SERV WFI sleep/wake controller: gates the core clock once the bit-serial
// counter drains, and re-enables it WAKE_CYCLES+1 edges after an enabled
// interrupt is seen.
// Optional feature macro: SERV_WAKE_CAUSE_EN adds a 2-bit last-wake-cause
// output (bit0 = timer, bit1 = external).
//
// state | meaning
// RUN   | core clocked, normal execution
// DRAIN | sleep requested, waiting for the counter's final cycle
// HALT  | core clock gated, waiting for an enabled interrupt
// WAKE  | clock settling countdown before re-enabling the core clock
module serv_wake_ctrl #(
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sleep_req,
    input  logic       i_cnt_done,
    input  logic       i_timer_irq,
    input  logic       i_external_irq,
    input  logic       i_mtie,
    input  logic       i_meie,
    output logic       o_clk_en,
    output logic       o_halted,
    output logic       o_wake
`ifdef SERV_WAKE_CAUSE_EN
    ,
    output logic [1:0] o_wake_cause
`endif
);
    import serv_wake_pkg::*;

    // Countdown start value; WAKE_CYCLES=0 bypasses WAKE entirely.
    localparam logic [CNT_W-1:0] WAKE_LOAD =
        CNT_W'((WAKE_CYCLES == 0) ? 0 : (WAKE_CYCLES - 1));

    wake_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_en_q;
    logic             halted_q;
    logic             wake_pulse_q;
    logic             wake;

    // Interrupt qualification ignores mstatus.MIE: WFI wakes on any enabled pending irq.
    assign wake = (i_timer_irq & i_mtie) | (i_external_irq & i_meie);

`ifdef SERV_WAKE_CAUSE_EN
    logic [1:0] cause_q;
    logic [1:0] cause_d;

    // Value captured into the cause register when leaving HALT.
    always_comb begin
        cause_d                  = 2'b00;
        cause_d[CAUSE_TIMER_BIT] = i_timer_irq & i_mtie;
        cause_d[CAUSE_EXT_BIT]   = i_external_irq & i_meie;
    end

    assign o_wake_cause = cause_q;
`endif

    // Sleep/wake FSM with settle counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            clk_en_q     <= 1'b1;
            halted_q     <= 1'b0;
            wake_pulse_q <= 1'b0;
`ifdef SERV_WAKE_CAUSE_EN
            cause_q      <= 2'b00;
`endif
        end else begin
            wake_pulse_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (i_sleep_req) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!i_sleep_req) begin
                        state_q <= ST_RUN;
                    end else if (i_cnt_done) begin
                        if (wake) begin
                            // Interrupt already pending: skip gating, resume immediately.
                            state_q      <= ST_RUN;
                            wake_pulse_q <= 1'b1;
                        end else begin
                            state_q  <= ST_HALT;
                            clk_en_q <= 1'b0;
                            halted_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (wake) begin
`ifdef SERV_WAKE_CAUSE_EN
                        cause_q <= cause_d;
`endif
                        if (WAKE_CYCLES == 0) begin
                            state_q      <= ST_RUN;
                            clk_en_q     <= 1'b1;
                            halted_q     <= 1'b0;
                            wake_pulse_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAKE;
                            cnt_q   <= WAKE_LOAD;
                        end
                    end
                end
                ST_WAKE: begin
                    // Committed once started: irq deassertion does not abort.
                    if (cnt_q == '0) begin
                        state_q      <= ST_RUN;
                        clk_en_q     <= 1'b1;
                        halted_q     <= 1'b0;
                        wake_pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign o_clk_en = clk_en_q;
    assign o_halted = halted_q;
    assign o_wake   = wake_pulse_q;

endmodule

// File: tb/tb_serv_wake_ctrl.sv
// Bench for serv_wake_ctrl: two instances (WAKE_CYCLES=0 and 2) share stimulus
// and are compared every cycle against an edge-count reference model.
module tb_serv_wake_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic sleep_req, cnt_done, timer_irq, ext_irq, mtie, meie;
    logic [1:0] clk_en_w, halted_w, wake_w;
`ifdef SERV_WAKE_CAUSE_EN
    logic [1:0] cause_w [2];
`endif

    always #5 clk = ~clk;

    serv_wake_ctrl #(.WAKE_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req), .i_cnt_done(cnt_done),
        .i_timer_irq(timer_irq), .i_external_irq(ext_irq), .i_mtie(mtie), .i_meie(meie),
        .o_clk_en(clk_en_w[0]), .o_halted(halted_w[0]), .o_wake(wake_w[0])
`ifdef SERV_WAKE_CAUSE_EN
        , .o_wake_cause(cause_w[0])
`endif
    );

    serv_wake_ctrl #(.WAKE_CYCLES(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req), .i_cnt_done(cnt_done),
        .i_timer_irq(timer_irq), .i_external_irq(ext_irq), .i_mtie(mtie), .i_meie(meie),
        .o_clk_en(clk_en_w[1]), .o_halted(halted_w[1]), .o_wake(wake_w[1])
`ifdef SERV_WAKE_CAUSE_EN
        , .o_wake_cause(cause_w[1])
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: tracks "draining", "clock gated" and the absolute edge
    // number at which the core resumes, instead of a per-cycle countdown.
    int        wc [2] = '{0, 2};
    int        edge_n;
    bit        m_drain [2];
    bit        m_gated [2];
    int        m_resume [2];
    bit        m_wake [2];
    logic [1:0] m_cause [2];

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < 2; i++) begin
            m_drain[i] = 0; m_gated[i] = 0; m_resume[i] = -1;
            m_wake[i] = 0; m_cause[i] = 2'b00;
        end
    endtask

    task automatic model_edge();
        bit w;
        w = (timer_irq & mtie) | (ext_irq & meie);
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            m_wake[i] = 0;
            if (m_gated[i]) begin
                if (m_resume[i] < 0 && w) begin
                    m_cause[i]  = {ext_irq & meie, timer_irq & mtie};
                    m_resume[i] = edge_n + wc[i];
                end
                if (m_resume[i] == edge_n) begin
                    m_gated[i] = 0; m_wake[i] = 1; m_resume[i] = -1;
                end
            end else if (m_drain[i]) begin
                if (!sleep_req) m_drain[i] = 0;
                else if (cnt_done) begin
                    m_drain[i] = 0;
                    if (w) m_wake[i] = 1;
                    else   m_gated[i] = 1;
                end
            end else if (sleep_req) begin
                m_drain[i] = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, (i == 0) ? "/wc0 clk_en" : "/wc2 clk_en"}, {1'b0, clk_en_w[i]}, {1'b0, ~m_gated[i]});
            check({tag, (i == 0) ? "/wc0 halted" : "/wc2 halted"}, {1'b0, halted_w[i]}, {1'b0, m_gated[i]});
            check({tag, (i == 0) ? "/wc0 wake"   : "/wc2 wake"},   {1'b0, wake_w[i]},   {1'b0, m_wake[i]});
`ifdef SERV_WAKE_CAUSE_EN
            check({tag, (i == 0) ? "/wc0 cause" : "/wc2 cause"}, cause_w[i], m_cause[i]);
`endif
        end
    endtask

    task automatic step(input string tag, input bit s, input bit c, input bit t,
                        input bit e, input bit mt, input bit me);
        sleep_req = s; cnt_done = c; timer_irq = t; ext_irq = e; mtie = mt; meie = me;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        sleep_req = 0; cnt_done = 0; timer_irq = 0; ext_irq = 0; mtie = 0; meie = 0;
        model_reset();
        #2;
        check_all("reset");
        #19;
        rst = 1'b0;
        step("post_reset", 0, 0, 0, 0, 0, 0);

        // Sleep with no interrupt, then external wake.
        step("req", 1, 0, 0, 0, 0, 0);
        check("req_clk_en_still1", {1'b0, clk_en_w[1]}, 2'b01);
        step("drain_done", 1, 1, 0, 0, 0, 0);
        check("halt_clk_en0", {1'b0, clk_en_w[1]}, 2'b00);
        check("halt_halted1", {1'b0, halted_w[1]}, 2'b01);
        step("ext_wake1", 0, 0, 0, 1, 0, 1);
        check("wc0_wake_next_edge", {1'b0, wake_w[0]}, 2'b01);
        step("ext_wake2", 0, 0, 0, 1, 0, 1);
        check("wc2_still_gated", {1'b0, clk_en_w[1]}, 2'b00);
        step("ext_wake3", 0, 0, 0, 1, 0, 1);
        check("wc2_resume_clk_en", {1'b0, clk_en_w[1]}, 2'b01);
        check("wc2_resume_wake", {1'b0, wake_w[1]}, 2'b01);
        step("wake_one_shot", 0, 0, 0, 0, 0, 0);
        check("wc2_wake_cleared", {1'b0, wake_w[1]}, 2'b00);

        // Interrupt already pending at the counter's final cycle.
        step("pend_req", 1, 0, 1, 0, 1, 0);
        step("pend_done", 1, 1, 1, 0, 1, 0);
        check("pend_clk_en", {1'b0, clk_en_w[1]}, 2'b01);
        check("pend_wake", {1'b0, wake_w[1]}, 2'b01);
        step("pend_after", 0, 0, 0, 0, 0, 0);

        // Masked timer interrupt must not wake.
        step("mask_req", 1, 0, 0, 0, 0, 0);
        step("mask_done", 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step("masked", k[0], 1, 1, 0, 0, 0);
        check("masked_halted", {1'b0, halted_w[1]}, 2'b01);
        step("unmask1", 0, 0, 1, 0, 1, 0);
        step("unmask2", 0, 0, 0, 0, 0, 0);
        step("unmask3", 0, 0, 0, 0, 0, 0);
        check("unmask_wc2_wake", {1'b0, wake_w[1]}, 2'b01);
`ifdef SERV_WAKE_CAUSE_EN
        check("cause_timer", cause_w[1], 2'b01);
`endif

        // Reset in the middle of the settle countdown.
        step("rst_req", 1, 0, 0, 0, 0, 0);
        step("rst_done", 1, 1, 0, 0, 0, 0);
        step("rst_wake", 0, 0, 0, 1, 0, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("midwake_rst_clk_en", {1'b0, clk_en_w[1]}, 2'b01);
        check("midwake_rst_halted", {1'b0, halted_w[1]}, 2'b00);
        check("midwake_rst_wake", {1'b0, wake_w[1]}, 2'b00);
        check_all("midwake_rst");
        #2;
        rst = 1'b0;
        step("after_rst1", 0, 0, 0, 0, 0, 0);
        step("after_rst2", 0, 0, 0, 0, 0, 0);

        // External wake with cause capture, then abort in DRAIN.
        step("c_req", 1, 0, 0, 0, 0, 0);
        step("c_done", 1, 1, 0, 0, 0, 0);
        step("c_ext", 0, 0, 0, 1, 0, 1);
        check("wc0_ext_wake", {1'b0, wake_w[0]}, 2'b01);
`ifdef SERV_WAKE_CAUSE_EN
        check("cause_ext", cause_w[0], 2'b10);
`endif
        step("c_settle1", 0, 0, 0, 0, 0, 0);
        step("c_settle2", 0, 0, 0, 0, 0, 0);
        step("abort_req", 1, 0, 0, 0, 0, 0);
        step("abort_drop", 0, 0, 0, 0, 0, 0);
        check("abort_no_wake", {1'b0, wake_w[0]}, 2'b00);
        check("abort_clk_en", {1'b0, clk_en_w[0]}, 2'b01);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step("rand",
                 ($urandom_range(9) < 7), ($urandom_range(9) < 4),
                 ($urandom_range(9) < 2), ($urandom_range(9) < 2),
                 $urandom_range(1), $urandom_range(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
